// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_control_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    JAL      = 4'd13,
    JR       = 4'd14
  } state_t;

  // Instruction classes produced by the decoder; the FSM dispatches on these.
  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_JR      = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JUMP    = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_IMM     = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_FUNCT = 4'd15;

  localparam logic [3:0] B_NONE    = 4'd0;
  localparam logic [3:0] B_EQ      = 4'd1;
  localparam logic [3:0] B_NE      = 4'd2;
  localparam logic [3:0] B_GTZ     = 4'd3;
  localparam logic [3:0] B_LEZ     = 4'd4;
  localparam logic [3:0] B_GEZ     = 4'd5;
  localparam logic [3:0] B_LTZ     = 4'd6;

endpackage

// File: rtl/mc_control_decode.sv
// rtl/mc_control_decode.sv - opcode decoder: instruction class, branch condition, immediate ALU op
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic [3:0]   branch_op,
  output logic [3:0]   imm_alu_op
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign rt          = instr[20:16];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[15:6]};

  // Classify the opcode; anything not listed falls through as illegal.
  always_comb begin
    cls        = CLS_ILLEGAL;
    branch_op  = B_NONE;
    imm_alu_op = ALU_ADD;
    case (op)
      OP_RTYPE:  cls = (funct == FN_JR) ? CLS_JR : CLS_R;
      OP_LW:     cls = CLS_LOAD;
      OP_SW:     cls = CLS_STORE;
      OP_BEQ:    begin cls = CLS_BRANCH; branch_op = B_EQ;  end
      OP_BNE:    begin cls = CLS_BRANCH; branch_op = B_NE;  end
      OP_BLEZ:   begin cls = CLS_BRANCH; branch_op = B_LEZ; end
      OP_BGTZ:   begin cls = CLS_BRANCH; branch_op = B_GTZ; end
      OP_REGIMM: begin
        if (rt == RT_BLTZ) begin
          cls       = CLS_BRANCH;
          branch_op = B_LTZ;
        end else if (rt == RT_BGEZ) begin
          cls       = CLS_BRANCH;
          branch_op = B_GEZ;
        end
      end
      OP_J:      cls = CLS_JUMP;
      OP_JAL:    cls = CLS_JAL;
      OP_ADDI,
      OP_ADDIU:  begin cls = CLS_IMM; imm_alu_op = ALU_ADD; end
      OP_ANDI:   begin cls = CLS_IMM; imm_alu_op = ALU_AND; end
      OP_ORI:    begin cls = CLS_IMM; imm_alu_op = ALU_OR;  end
      OP_SLTI:   begin cls = CLS_IMM; imm_alu_op = ALU_SLT; end
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main control state machine
module mc_control
  import mc_control_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch,
  output logic [3:0]  branch_op,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [3:0]  state_dbg
);

  localparam int            CW      = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_PRE = CW'(WAIT_MAX - 1);

  state_t       state, next_state;
  instr_class_t cls;
  logic [3:0]   dec_branch_op;
  logic [3:0]   imm_alu_op;
  logic [CW-1:0] wait_cnt;
  logic         access;

  mc_decode u_decode (
    .instr      (instr),
    .cls        (cls),
    .branch_op  (dec_branch_op),
    .imm_alu_op (imm_alu_op)
  );

  assign access    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign state_dbg = state;

  // State register; reset parks the machine in IDLE, which drops every output at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Memory wait counter and one-shot timeout flag; every access leaves on mem_ready, so that clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_timeout <= access && !mem_ready && (wait_cnt == CNT_PRE);
      if (!access || mem_ready) wait_cnt <= '0;
      else if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state and Moore outputs; only FETCH's ir_write/pc_write look at mem_ready.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_op  = B_NONE;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 4'd0;
    illegal    = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (cls)
          CLS_R:                next_state = EXEC_R;
          CLS_JR:               next_state = JR;
          CLS_LOAD, CLS_STORE:  next_state = MEM_ADDR;
          CLS_BRANCH:           next_state = BRANCH;
          CLS_JUMP:             next_state = JUMP;
          CLS_JAL:              next_state = JAL;
          CLS_IMM:              next_state = EXEC_I;
          default: begin
            illegal    = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = WB_R;
      end
      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        next_state = FETCH;
      end
      EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = imm_alu_op;
        next_state = WB_I;
      end
      WB_I: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_op     = ALU_ADD;
        next_state = (cls == CLS_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = WB_MEM;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        next_state = FETCH;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      BRANCH: begin
        branch     = 1'b1;
        branch_op  = dec_branch_op;
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        next_state = FETCH;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        next_state = FETCH;
      end
      JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'd3;
        next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_WB_R = 4'd4, S_EXEC_I = 4'd5, S_WB_I = 4'd6, S_MEM_ADDR = 4'd7,
                         S_MEM_RD = 4'd8, S_WB_MEM = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
                         S_JUMP = 4'd12, S_JAL = 4'd13, S_JR = 4'd14;
  localparam logic [3:0] A_OR = 4'd1, A_ADD = 4'd2, A_SUB = 4'd6, A_FUNCT = 4'd15;
  localparam logic [3:0] BC_EQ = 4'd1, BC_NE = 4'd2, BC_GEZ = 4'd5, BC_LTZ = 4'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, iord, ir_write, pc_write, branch;
  logic [3:0]  branch_op, alu_op, state_dbg;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic        reg_write, alu_src_a, illegal, mem_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;

  mc_control #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .branch_op(branch_op), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    reset = 1'b1; mem_ready = 1'b1; instr = 32'h00221820;
    tick(); tick();
    outs = {mem_req, mem_we, iord, ir_write, pc_write, branch, branch_op, pc_src, reg_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, mem_timeout};
    total_cnt++;
    if (state_dbg !== S_IDLE) $display("FAIL reset_state got %0d want %0d", state_dbg, S_IDLE);
    else pass_cnt++;
    total_cnt++;
    if (outs !== 32'h0) $display("FAIL reset_outputs got %h want 0", outs);
    else pass_cnt++;
  endtask

  task automatic test_r_type();
    logic [3:0] exp_seq [5] = '{S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_FETCH};
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (state_dbg !== exp_seq[i]) $display("FAIL rtype_seq[%0d] got %0d want %0d", i, state_dbg, exp_seq[i]);
      else pass_cnt++;
      total_cnt++;
      if ({reg_write, reg_dst} !== ((i == 3) ? 3'b101 : 3'b000))
        $display("FAIL rtype_regwrite[%0d] got %b", i, {reg_write, reg_dst});
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if ({mem_req, iord, ir_write, pc_write, alu_src_a, alu_src_b, alu_op, pc_src} !== {5'b10110, 2'd1, A_ADD, 2'd0})
          $display("FAIL fetch_outputs got %b", {mem_req, iord, ir_write, pc_write, alu_src_a, alu_src_b, alu_op, pc_src});
        else pass_cnt++;
      end
      if (i == 1) begin
        total_cnt++;
        if ({alu_src_a, alu_src_b, alu_op} !== {1'b0, 2'd3, A_ADD})
          $display("FAIL decode_outputs got %b", {alu_src_a, alu_src_b, alu_op});
        else pass_cnt++;
      end
      if (i == 2) begin
        total_cnt++;
        if ({alu_src_a, alu_src_b, alu_op} !== {1'b1, 2'd0, A_FUNCT})
          $display("FAIL exec_r_outputs got %b", {alu_src_a, alu_src_b, alu_op});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_lw_wait();
    instr = 32'h8C220004; mem_ready = 1'b1;
    tick(); tick();
    total_cnt++;
    if (state_dbg !== S_MEM_ADDR || alu_src_b !== 2'd2) $display("FAIL lw_mem_addr got state %0d srcb %0d", state_dbg, alu_src_b);
    else pass_cnt++;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({state_dbg, mem_req, iord, mem_we, mem_timeout} !== {S_MEM_RD, 4'b1100})
        $display("FAIL lw_wait[%0d] got state %0d req %b iord %b we %b to %b", i, state_dbg, mem_req, iord, mem_we, mem_timeout);
      else pass_cnt++;
      if (i == 2) mem_ready = 1'b1;
    end
    tick();
    total_cnt++;
    if ({state_dbg, reg_write, reg_dst, mem_to_reg, mem_req} !== {S_WB_MEM, 1'b1, 2'd0, 2'd1, 1'b0})
      $display("FAIL lw_wb got state %0d rw %b dst %0d m2r %0d req %b", state_dbg, reg_write, reg_dst, mem_to_reg, mem_req);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (state_dbg !== S_FETCH) $display("FAIL lw_return got %0d want %0d", state_dbg, S_FETCH);
    else pass_cnt++;
  endtask

  task automatic test_branch(input logic [31:0] word, input logic [3:0] exp_op);
    instr = word;
    tick(); tick();
    total_cnt++;
    if ({state_dbg, branch, branch_op, pc_src, alu_src_a, alu_src_b, alu_op, pc_write} !==
        {S_BRANCH, 1'b1, exp_op, 2'd1, 1'b1, 2'd0, A_SUB, 1'b0})
      $display("FAIL branch_%h got state %0d br %b op %0d src %0d alu %0d want op %0d",
               word, state_dbg, branch, branch_op, pc_src, alu_op, exp_op);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (state_dbg !== S_FETCH || branch_op !== 4'd0 || branch !== 1'b0)
      $display("FAIL branch_after_%h got state %0d op %0d br %b", word, state_dbg, branch_op, branch);
    else pass_cnt++;
  endtask

  task automatic test_ori();
    instr = 32'h34220055;
    tick(); tick();
    total_cnt++;
    if ({state_dbg, alu_src_a, alu_src_b, alu_op} !== {S_EXEC_I, 1'b1, 2'd2, A_OR})
      $display("FAIL ori_exec got state %0d srca %b srcb %0d op %0d", state_dbg, alu_src_a, alu_src_b, alu_op);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state_dbg, reg_write, reg_dst, mem_to_reg} !== {S_WB_I, 1'b1, 2'd0, 2'd0})
      $display("FAIL ori_wb got state %0d rw %b dst %0d", state_dbg, reg_write, reg_dst);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_jumps();
    instr = 32'h0C000010;
    tick(); tick();
    total_cnt++;
    if ({state_dbg, pc_write, pc_src, reg_write, reg_dst, mem_to_reg} !== {S_JAL, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2})
      $display("FAIL jal got state %0d pcw %b src %0d rw %b dst %0d m2r %0d", state_dbg, pc_write, pc_src, reg_write, reg_dst, mem_to_reg);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (state_dbg !== S_FETCH) $display("FAIL jal_single got %0d want %0d", state_dbg, S_FETCH);
    else pass_cnt++;
    instr = 32'h08000020;
    tick(); tick();
    total_cnt++;
    if ({state_dbg, pc_write, pc_src, reg_write} !== {S_JUMP, 1'b1, 2'd2, 1'b0})
      $display("FAIL j got state %0d pcw %b src %0d", state_dbg, pc_write, pc_src);
    else pass_cnt++;
    tick();
    instr = 32'h03E00008;
    tick(); tick();
    total_cnt++;
    if ({state_dbg, pc_write, pc_src, reg_write} !== {S_JR, 1'b1, 2'd3, 1'b0})
      $display("FAIL jr got state %0d pcw %b src %0d", state_dbg, pc_write, pc_src);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_illegal();
    instr = 32'hFC000000;
    tick();
    total_cnt++;
    if ({state_dbg, illegal, reg_write, pc_write} !== {S_DECODE, 3'b100})
      $display("FAIL illegal_decode got state %0d ill %b rw %b pcw %b", state_dbg, illegal, reg_write, pc_write);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (state_dbg !== S_FETCH || illegal !== 1'b0) $display("FAIL illegal_next got state %0d ill %b", state_dbg, illegal);
    else pass_cnt++;
    instr = 32'h04420000;
    tick();
    total_cnt++;
    if (illegal !== 1'b1) $display("FAIL regimm_bad_rt got %b want 1", illegal);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    int pulse_at;
    instr = 32'hAC220004; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    total_cnt++;
    if ({state_dbg, mem_req, mem_we, iord} !== {S_MEM_WR, 3'b111})
      $display("FAIL sw_access got state %0d req %b we %b iord %b", state_dbg, mem_req, mem_we, iord);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if ({mem_req, mem_we, state_dbg} !== {2'b00, S_IDLE})
      $display("FAIL async_reset got req %b we %b state %0d", mem_req, mem_we, state_dbg);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (state_dbg !== S_FETCH || ir_write !== 1'b0 || pc_write !== 1'b0)
      $display("FAIL restart_fetch got state %0d irw %b pcw %b", state_dbg, ir_write, pc_write);
    else pass_cnt++;
    pulses = 0; pulse_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_timeout) begin pulses++; pulse_at = c; end
      if (c < 20) tick();
    end
    total_cnt++;
    if (pulses !== 1 || pulse_at !== 16) $display("FAIL timeout_pulse got count %0d at cycle %0d want 1 at 16", pulses, pulse_at);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== S_FETCH) $display("FAIL timeout_keeps_waiting got %0d want %0d", state_dbg, S_FETCH);
    else pass_cnt++;
    mem_ready = 1'b1;
    tick();
    total_cnt++;
    if (state_dbg !== S_DECODE || mem_timeout !== 1'b0) $display("FAIL after_timeout got state %0d to %b", state_dbg, mem_timeout);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch(32'h10220003, BC_EQ);
    test_branch(32'h14220003, BC_NE);
    test_branch(32'h04200002, BC_LTZ);
    test_branch(32'h04210002, BC_GEZ);
    test_ori();
    test_jumps();
    test_illegal();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
